bcd2binary: RTL and testbench

Sequential BCD-to-binary converter for the 8-bit TRISC calculator's digit-entry path. It accepts a three-digit BCD operand (hundreds, tens, ones), converts it to an 8-bit unsigned binary value, and flags out-of-range or malformed digits. It is the inverse of the display-side binary-to-BCD path: keypad digits are converted here before they reach the ALU operand registers. The conversion uses an iterative reverse double-dabble with a start/done handshake.

---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bcd_sub3.sv | 17 +
 rtl/bcd2binary.sv | 131 +++++++++++++
 tb/tb_bcd2binary.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StDone
  } state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam int unsigned N_ITER        = 10;
  localparam int unsigned BIN_MAX       = 255;
  localparam int unsigned BCD_MAX_DIGIT = 9;

  // True when a digit lies outside 0-9.
  function automatic logic digit_bad(input bcd_digit_t d);
    return d > 4'(BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_sub3.sv
// Reverse double-dabble digit corrector: subtract 3 when the digit is >= 8.
module bcd_sub3
  import bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // Pure combinational correction of one shifted BCD digit.
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd8) begin
      digit_o = digit_i - 4'd3;
    end
  end

endmodule

// File: rtl/bcd2binary.sv
// Iterative three-digit BCD to 8-bit binary converter with start/done handshake.
// Build option: define BCD2BIN_SATURATE_EN to clamp overflowing results to 8'hFF;
// otherwise an overflowing result wraps to the low 8 bits.
module bcd2binary
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       overflow,
  output logic       invalid
);

  state_e      state_q, state_d;
  logic [11:0] bcd_q, bcd_d;
  logic [9:0]  bin_q, bin_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  result_q, result_d;
  logic        overflow_q, overflow_d;
  logic        invalid_q, invalid_d;

  logic [21:0] shifted;
  logic [11:0] bcd_corr;
  logic [9:0]  bin_next;
  logic        bin_ovf;
  logic        any_bad;

  assign shifted  = {bcd_q, bin_q} >> 1;
  assign bin_next = shifted[9:0];
  assign bin_ovf  = bin_next > 10'(BIN_MAX);
  assign any_bad  = digit_bad(hundreds) | digit_bad(tens) | digit_bad(ones);

  bcd_sub3 u_sub3_hundreds (
    .digit_i (shifted[21:18]),
    .digit_o (bcd_corr[11:8])
  );

  bcd_sub3 u_sub3_tens (
    .digit_i (shifted[17:14]),
    .digit_o (bcd_corr[7:4])
  );

  bcd_sub3 u_sub3_ones (
    .digit_i (shifted[13:10]),
    .digit_o (bcd_corr[3:0])
  );

  // Next-state logic: accept in idle, one shift/correct step per conversion cycle.
  always_comb begin
    state_d    = state_q;
    bcd_d      = bcd_q;
    bin_d      = bin_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    invalid_d  = invalid_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          bcd_d      = {hundreds, tens, ones};
          bin_d      = '0;
          cnt_d      = '0;
          result_d   = '0;
          overflow_d = 1'b0;
          invalid_d  = any_bad;
          state_d    = StConv;
        end
      end
      StConv: begin
        if (invalid_q) begin
          // Malformed operand: result stays 0, spend exactly one cycle here.
          state_d = StDone;
        end else begin
          bcd_d = bcd_corr;
          bin_d = bin_next;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'(N_ITER - 1)) begin
            state_d    = StDone;
            overflow_d = bin_ovf;
`ifdef BCD2BIN_SATURATE_EN
            result_d   = bin_ovf ? 8'hFF : bin_next[7:0];
`else
            result_d   = bin_next[7:0];
`endif
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bcd_q      <= '0;
      bin_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      invalid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcd_q      <= bcd_d;
      bin_q      <= bin_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      invalid_q  <= invalid_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign result   = result_q;
  assign overflow = overflow_q;
  assign invalid  = invalid_q;

endmodule

// File: tb/tb_bcd2binary.sv
// Directed self-checking bench for bcd2binary.
module tb_bcd2binary;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       overflow;
  logic       invalid;

  int n_checks = 0;
  int n_errors = 0;

  bcd2binary u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .hundreds (hundreds),
    .tens     (tens),
    .ones     (ones),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow),
    .invalid  (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One accepted conversion; checks latency, single-cycle done and final outputs.
  task automatic do_conv(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                         input logic [7:0] exp_res, input logic exp_ovf, input logic exp_inv,
                         input int exp_lat);
    int lat;
    @(negedge clk);
    hundreds = h;
    tens     = t;
    ones     = o;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    check("busy_after_accept", 32'(busy), 32'd1);
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("busy_in_done", 32'(busy), 32'd1);
    check("result", 32'(result), 32'(exp_res));
    check("overflow", 32'(overflow), 32'(exp_ovf));
    check("invalid", 32'(invalid), 32'(exp_inv));
    hundreds = 4'h3;
    tens     = 4'h3;
    ones     = 4'h3;
    @(negedge clk);
    check("done_single_cycle", 32'(done), 32'd0);
    check("busy_cleared", 32'(busy), 32'd0);
    check("result_held", 32'(result), 32'(exp_res));
  endtask

  logic [7:0] exp_999;
  logic [7:0] exp_256;
  int         pulses;

  initial begin
`ifdef BCD2BIN_SATURATE_EN
    exp_999 = 8'hFF;
    exp_256 = 8'hFF;
`else
    exp_999 = 8'hE7;
    exp_256 = 8'h00;
`endif
    rst_n    = 1'b0;
    start    = 1'b0;
    hundreds = 4'h0;
    tens     = 4'h0;
    ones     = 4'h0;
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_invalid", 32'(invalid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    do_conv(4'd2, 4'd5, 4'd5, 8'hFF, 1'b0, 1'b0, 10);
    do_conv(4'd1, 4'd2, 4'd8, 8'h80, 1'b0, 1'b0, 10);
    do_conv(4'd0, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0, 10);
    do_conv(4'd9, 4'd9, 4'd9, exp_999, 1'b1, 1'b0, 10);
    do_conv(4'd2, 4'd5, 4'd6, exp_256, 1'b1, 1'b0, 10);
    do_conv(4'd1, 4'd2, 4'hA, 8'h00, 1'b0, 1'b1, 1);
    do_conv(4'd0, 4'd1, 4'd7, 8'h11, 1'b0, 1'b0, 10);

    // start re-asserted mid-conversion with different digits must be ignored.
    @(negedge clk);
    hundreds = 4'd1;
    tens     = 4'd2;
    ones     = 4'd8;
    start    = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 15; k++) begin
      if (k == 3) begin
        hundreds = 4'd9;
        tens     = 4'd9;
        ones     = 4'd9;
        start    = 1'b1;
      end
      if (k == 4) start = 1'b0;
      @(negedge clk);
      if (done) pulses++;
    end
    check("ignored_start_pulses", 32'(pulses), 32'd1);
    check("ignored_start_result", 32'(result), 32'h80);
    check("ignored_start_overflow", 32'(overflow), 32'd0);

    // Preload a nonzero result, then reset in the middle of the next conversion.
    do_conv(4'd0, 4'd6, 4'd4, 8'h40, 1'b0, 1'b0, 10);
    @(negedge clk);
    hundreds = 4'd1;
    tens     = 4'd5;
    ones     = 4'd0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 5; k++) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_result", 32'(result), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    check("no_done_after_rst", 32'(pulses), 32'd0);
    do_conv(4'd0, 4'd4, 4'd2, 8'h2A, 1'b0, 1'b0, 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
